dfs_cfg_sequencer: RTL and testbench

Sequencer between the DVFS policy logic and the MMCM reconfiguration engine of the DFS unit. It accepts a frequency-index request and reads the 36-bit MMCM lookup BRAM and the 18-bit obtained-frequency BRAM at that index. It decodes the M/D/O fields, hands them to the reconfiguration engine over a valid/ready handshake, and waits for MMCM lock with a timeout. It then reports completion, the obtained frequency, or an error.

---
 rtl/dfs_cfg_sequencer.sv | 99 +++++++++
 tb/tb_dfs_cfg_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dfs_cfg_sequencer.sv
// dfs_cfg_sequencer: reads MMCM lookup and frequency BRAMs for a request, hands
// the decoded M/D/O fields to the reconfiguration engine and waits for lock.
module dfs_cfg_sequencer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int LOCK_TIMEOUT = 4095
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  bram36_en,
  output logic [ADDR_WIDTH-1:0] bram36_addr,
  input  logic [35:0]           bram36_dout,
  output logic                  bram18_en,
  output logic [ADDR_WIDTH-1:0] bram18_addr,
  input  logic [17:0]           bram18_dout,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  output logic [5:0]            cfg_m,
  output logic [5:0]            cfg_d,
  output logic [5:0]            cfg_o_int,
  output logic [2:0]            cfg_o_frac,
  output logic                  cfg_o_frac_en,
  input  logic                  mmcm_locked,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [12:0]           cur_freq,
  output logic                  cur_valid
);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RD, DEC, CFG, LOCK, DONE} state_t;
  state_t state, next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0] cnt;
  logic [12:0] freq;
  logic bad, lock_ok, timeout, unused_bits;
  assign unused_bits = ^{bram36_dout[35:23], bram36_dout[0], bram18_dout[4:0]};
  assign bad = bram36_dout[22:17] == 6'd0 || bram36_dout[16:11] == 6'd0;
  // lock is masked for the first two LOCK cycles so a stale lock is not taken as new
  assign lock_ok = cnt >= CW'(2) && mmcm_locked;
  assign timeout = cnt == CW'(LOCK_TIMEOUT);
  assign bram36_addr = addr;
  assign bram18_addr = addr;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = req_valid ? RD : IDLE;
      RD:      next = DEC;
      DEC:     next = bad ? IDLE : CFG;
      CFG:     next = cfg_ready ? LOCK : CFG;
      LOCK:    next = lock_ok ? DONE : timeout ? IDLE : LOCK;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
    req_ready = state == IDLE;
    busy      = state != IDLE;
    bram36_en = state == RD;
    bram18_en = state == RD;
    cfg_valid = state == CFG;
    done      = state == DONE;
    err       = (state == DEC && bad) || (state == LOCK && !lock_ok && timeout);
    err_code  = (state == DEC && bad) ? 2'b01 : (state == LOCK && !lock_ok && timeout) ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      addr          <= '0;
      cnt           <= '0;
      freq          <= '0;
      cfg_m         <= '0;
      cfg_d         <= '0;
      cfg_o_int     <= '0;
      cfg_o_frac    <= '0;
      cfg_o_frac_en <= 1'b0;
      cur_freq      <= '0;
      cur_valid     <= 1'b0;
    end else begin
      state <= next;
      cnt   <= state == LOCK ? cnt + CW'(1) : '0;
      if (state == IDLE && req_valid) addr <= req_addr;
      if (state == DEC) begin
        cfg_m         <= bram36_dout[22:17];
        cfg_d         <= bram36_dout[16:11];
        cfg_o_int     <= bram36_dout[10:5];
        cfg_o_frac    <= bram36_dout[4:2];
        cfg_o_frac_en <= bram36_dout[1];
        freq          <= bram18_dout[17:5];
      end
      if (state == DEC && !bad) cur_valid <= 1'b0;
      if (state == DONE) begin
        cur_freq  <= freq;
        cur_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dfs_cfg_sequencer.sv
// tb_dfs_cfg_sequencer: random-stimulus bench; expected cycle timeline of each
// request is computed arithmetically from the entry, ready delay and lock time.
module tb_dfs_cfg_sequencer;
  localparam int AW = 10;
  localparam int TO = 20;
  logic clk = 0, rstn = 0, req_valid = 0, cfg_ready = 0, mmcm_locked = 0;
  logic [AW-1:0] req_addr = '0;
  logic req_ready, bram36_en, bram18_en, cfg_valid, cfg_o_frac_en, busy, done, err, cur_valid;
  logic [AW-1:0] bram36_addr, bram18_addr;
  logic [35:0] d36 = '0;
  logic [17:0] d18 = '0;
  logic [5:0] cfg_m, cfg_d, cfg_o_int;
  logic [2:0] cfg_o_frac;
  logic [1:0] err_code;
  logic [12:0] cur_freq;
  logic [35:0] mem36 [1024];
  logic [17:0] mem18 [1024];
  int errors = 0, checks = 0;
  logic [12:0] cur_f_m = '0;
  logic cur_v_m = 1'b0;

  dfs_cfg_sequencer #(.ADDR_WIDTH(AW), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .bram36_en(bram36_en), .bram36_addr(bram36_addr), .bram36_dout(d36),
    .bram18_en(bram18_en), .bram18_addr(bram18_addr), .bram18_dout(d18),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_m(cfg_m), .cfg_d(cfg_d),
    .cfg_o_int(cfg_o_int), .cfg_o_frac(cfg_o_frac), .cfg_o_frac_en(cfg_o_frac_en),
    .mmcm_locked(mmcm_locked), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .cur_freq(cur_freq), .cur_valid(cur_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram36_en) d36 <= mem36[bram36_addr];
    if (bram18_en) d18 <= mem18[bram18_addr];
  end

  function automatic logic [64:0] all_outs();
    return {req_ready, busy, bram36_en, bram18_en, bram36_addr, bram18_addr, cfg_valid,
            cfg_m, cfg_d, cfg_o_int, cfg_o_frac, cfg_o_frac_en, done, err, err_code, cur_freq, cur_valid};
  endfunction

  // lk_abs: cycle (relative to acceptance) from which mmcm_locked is high
  task automatic run_req(input int a, input int rdly, input int lk_abs, input string name);
    logic [35:0] e;
    logic [17:0] f;
    logic good;
    logic [1:0] ec;
    logic [8:0] obs, exp_v;
    int lock_start, seen, done_k, err_k, last, hs;
    e = mem36[a];
    f = mem18[a];
    good = e[22:17] != 0 && e[16:11] != 0;
    lock_start = 4 + rdly;
    seen = lk_abs > lock_start + 2 ? lk_abs : lock_start + 2;
    done_k = -1; err_k = -1; ec = 2'b00; hs = 0;
    if (!good) begin err_k = 2; ec = 2'b01; end
    else if (seen <= lock_start + TO) done_k = seen + 1;
    else begin err_k = lock_start + TO; ec = 2'b10; end
    last = done_k >= 0 ? done_k : err_k;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      req_valid = k == 0;
      req_addr = AW'(a);
      cfg_ready = k >= 3 + rdly;
      mmcm_locked = k >= lk_abs;
      #1;
      obs = {req_ready, busy, bram36_en, bram18_en, cfg_valid, done, err, err_code};
      exp_v = {k == 0, k > 0, k == 1, k == 1, good && k >= 3 && k <= 3 + rdly, k == done_k, k == err_k,
               k == err_k ? ec : 2'b00};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s ctrl k=%0d got=%b exp=%b", name, k, obs, exp_v);
      end
      checks++;
      if ({cur_valid, cur_freq} !== {(good && k >= 3) ? 1'b0 : cur_v_m, cur_f_m}) begin
        errors++;
        $display("FAIL %s cur k=%0d got=%b/%0d exp=%b/%0d", name, k, cur_valid, cur_freq,
                 (good && k >= 3) ? 1'b0 : cur_v_m, cur_f_m);
      end
      if (k >= 1) begin
        checks++;
        if (bram36_addr !== AW'(a) || bram18_addr !== AW'(a)) begin
          errors++;
          $display("FAIL %s addr k=%0d got=%0d/%0d exp=%0d", name, k, bram36_addr, bram18_addr, a);
        end
      end
      if (good && k >= 3 && k <= 3 + rdly) begin
        checks++;
        if ({cfg_m, cfg_d, cfg_o_int, cfg_o_frac, cfg_o_frac_en} !== e[22:1]) begin
          errors++;
          $display("FAIL %s fields k=%0d got=%h exp=%h", name, k,
                   {cfg_m, cfg_d, cfg_o_int, cfg_o_frac, cfg_o_frac_en}, e[22:1]);
        end
      end
      hs += int'(cfg_valid && cfg_ready);
    end
    req_valid = 0; cfg_ready = 0; mmcm_locked = 0;
    checks++;
    if (hs != (good ? 1 : 0)) begin
      errors++;
      $display("FAIL %s handshakes got=%0d exp=%0d", name, hs, good ? 1 : 0);
    end
    if (done_k >= 0) begin cur_f_m = f[17:5]; cur_v_m = 1'b1; end
    else if (good) cur_v_m = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (all_outs() !== {1'b1, 64'd0}) begin
      errors++;
      $display("FAIL reset outs got=%h exp=%h", all_outs(), {1'b1, 64'd0});
    end
    rstn = 1;
    cur_f_m = '0; cur_v_m = 1'b0;
  endtask

  task automatic test_basic();
    mem36[5] = {13'h1abc, 6'd10, 6'd1, 6'd5, 3'd0, 1'b0, 1'b0};
    mem18[5] = {13'd100, 5'd7};
    run_req(5, 0, 7, "basic");
    @(negedge clk); #1;
    checks++;
    if (cur_freq !== 13'd100 || cur_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_cur got=%0d/%b exp=100/1", cur_freq, cur_valid);
    end
  endtask

  task automatic test_backpressure();
    run_req(5, 4, 11, "backpressure");
  endtask

  task automatic test_invalid();
    mem36[7] = {13'h0, 6'd0, 6'd3, 6'd4, 3'd1, 1'b1, 1'b0};
    mem36[8] = {13'h0, 6'd9, 6'd0, 6'd4, 3'd1, 1'b1, 1'b1};
    run_req(7, 0, 0, "invalid_m");
    run_req(8, 2, 0, "invalid_d");
  endtask

  task automatic test_timeout();
    mem36[9] = {13'h0, 6'd20, 6'd2, 6'd8, 3'd5, 1'b1, 1'b0};
    mem18[9] = {13'd250, 5'd0};
    run_req(9, 1, 1000, "timeout");
  endtask

  task automatic test_stuck_lock();
    run_req(9, 0, 0, "stuck_lock");
  endtask

  task automatic test_reset_mid_cfg();
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      req_valid = k == 0;
      req_addr = AW'(5);
      cfg_ready = 0;
      #1;
    end
    checks++;
    if (cfg_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_cfg got=%b exp=1", cfg_valid);
    end
    rstn = 0;
    @(negedge clk); #1;
    checks++;
    if (all_outs() !== {1'b1, 64'd0}) begin
      errors++;
      $display("FAIL midrst_outs got=%h exp=%h", all_outs(), {1'b1, 64'd0});
    end
    rstn = 1;
    cur_f_m = '0; cur_v_m = 1'b0;
    run_req(5, 1, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int a, rdly, lk, mode;
    logic [35:0] e;
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(16, 1023);
      if ($urandom_range(0, 4) == 0) begin
        e = mem36[a];
        if ($urandom_range(0, 1) == 1) e[22:17] = 6'd0; else e[16:11] = 6'd0;
        mem36[a] = e;
      end
      rdly = $urandom_range(0, 3);
      mode = $urandom_range(0, 5);
      lk = mode == 0 ? 0 : mode == 1 ? 1000 : 4 + rdly + $urandom_range(0, 8);
      run_req(a, rdly, lk, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem36[i] = 36'({$urandom(), $urandom()});
      mem18[i] = 18'($urandom());
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_invalid();
    test_timeout();
    test_stuck_lock();
    test_reset_mid_cfg();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
